// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, types and write-port arbitration helper
//               for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NREGS    = 32;
    localparam int DEF_NREAD    = 2;
    localparam int DEF_NWRITE   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_ADDR_W   = $clog2(DEF_NREGS);

    // Widest write-port match vector the arbitration helper handles
    localparam int MAX_WPORTS   = 8;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] regidx_t;

    // One-hot of the highest-index set bit: the highest write port wins
    function automatic logic [MAX_WPORTS-1:0] win_port(input logic [MAX_WPORTS-1:0] hit);
        logic [MAX_WPORTS-1:0] onehot;
        onehot = '0;
        for (int j = 0; j < MAX_WPORTS; j++) begin
            if (hit[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_if
// Description : Read, write, reservation and scoreboard signals of the
//               multi-port register file, with issue/writeback (master) and
//               register-file (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int ADDR_W = $clog2(NREGS);

    logic [NREAD-1:0][ADDR_W-1:0]  rsel;
    logic [NREAD-1:0][DATA_W-1:0]  rdat;
    logic [NREAD-1:0]              rbusy;
    logic [NWRITE-1:0]             wen;
    logic [NWRITE-1:0][ADDR_W-1:0] wsel;
    logic [NWRITE-1:0][DATA_W-1:0] wdat;
    logic                          rsv_en;
    logic [ADDR_W-1:0]             rsv_sel;
    logic                          rsv_ok;
    logic                          flush;
    logic [NREGS-1:0]              busy;

    modport master (
        output rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
        input  rdat, rbusy, rsv_ok, busy
    );

    modport slave (
        input  rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
        output rdat, rbusy, rsv_ok, busy
    );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy bits. Issue reserves a destination,
//               writeback clears it, flush drops every reservation.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  wire logic                     CLK,
    input  wire logic                     nRST,
    input  wire logic                     rsv_en,
    input  wire logic [$clog2(NREGS)-1:0] rsv_sel,
    input  wire logic [NREGS-1:0]         clr,
    input  wire logic                     flush,
    output logic      [NREGS-1:0]         busy,
    output logic                          rsv_ok
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rsv_zero;

    // Accept/refuse the reservation and form the next busy vector;
    // a reservation beats a same-cycle clear, flush beats everything
    always_comb begin
        rsv_zero = (ZERO_REG != 0) && (rsv_sel == '0);
        rsv_ok   = nRST && rsv_en && !flush && (rsv_zero || !busy_q[rsv_sel]);
        busy_d   = busy_q & ~clr;
        if (rsv_ok && !rsv_zero) begin
            busy_d[rsv_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Busy vector state, cleared asynchronously on reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Parametrised multi-port register file with async read
//               ports, sync write ports, optional zero register, optional
//               write-to-read bypass and an integrated busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int NREAD    = DEF_NREAD,
    parameter int NWRITE   = DEF_NWRITE,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input wire logic          CLK,
    input wire logic          nRST,
    register_file_mp_if.slave bus
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;
    logic [NREGS-1:0]             wr_clr;
    logic [NWRITE-1:0]            wr_acc;

    // A write is accepted unless it targets the hardwired zero register
    always_comb begin
        wr_acc = '0;
        for (int j = 0; j < NWRITE; j++) begin
            wr_acc[j] = bus.wen[j] && !((ZERO_REG != 0) && (bus.wsel[j] == '0));
        end
    end

    // Apply accepted writes in port order so the highest port wins,
    // and collect which registers get their busy bit cleared
    always_comb begin
        regs_d = regs_q;
        wr_clr = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_acc[j]) begin
                regs_d[bus.wsel[j]] = bus.wdat[j];
                wr_clr[bus.wsel[j]] = 1'b1;
            end
        end
    end

    // Register storage, cleared asynchronously on reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [MAX_WPORTS-1:0] hit;
        logic [MAX_WPORTS-1:0] win;
        logic [DATA_W-1:0]     rd_val;
        logic                  rb_val;

        // Read mux with forwarding of the winning same-cycle write
        always_comb begin
            hit = '0;
            for (int j = 0; j < NWRITE; j++) begin
                hit[j] = (BYPASS != 0) && wr_acc[j] && (bus.wsel[j] == bus.rsel[i]);
            end
            win    = win_port(hit);
            rd_val = regs_q[bus.rsel[i]];
            for (int j = 0; j < NWRITE; j++) begin
                if (win[j]) begin
                    rd_val = bus.wdat[j];
                end
            end
            rb_val = bus.busy[bus.rsel[i]] && !((BYPASS != 0) && wr_clr[bus.rsel[i]]);
        end

        assign bus.rdat[i]  = rd_val;
        assign bus.rbusy[i] = rb_val;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK     (CLK),
        .nRST    (nRST),
        .rsv_en  (bus.rsv_en),
        .rsv_sel (bus.rsv_sel),
        .clr     (wr_clr),
        .flush   (bus.flush),
        .busy    (bus.busy),
        .rsv_ok  (bus.rsv_ok)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_mp
// Description : Self-checking bench for register_file_mp: directed vector
//               table on the default configuration, mid-cycle reset, and a
//               random sweep of a 16x4R1W no-bypass instance against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    logic CLK;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    register_file_mp_if #(.DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bus_a ();
    register_file_mp_if #(.DATA_W(32), .NREGS(16), .NREAD(4), .NWRITE(1)) bus_b ();

    register_file_mp #(
        .DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_a)
    );

    register_file_mp #(
        .DATA_W(32), .NREGS(16), .NREAD(4), .NWRITE(1), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w0;  logic [4:0] ws0; logic [31:0] wd0;
        logic        w1;  logic [4:0] ws1; logic [31:0] wd1;
        logic [4:0]  rs0; logic [4:0] rs1;
        logic        re;  logic [4:0] rsl; logic        fl;
        logic [31:0] e_rd0; logic [31:0] e_rd1;
        logic        e_rb0; logic        e_rb1; logic   e_ok;
        logic [31:0] e_busy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    typedef struct {
        logic [3:0][31:0] rd;
        logic [3:0]       rb;
        logic             ok;
        logic [15:0]      bz;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] regs_m[16];
    logic [15:0] busy_m;

    initial begin
        //           w0    ws0    wd0           w1    ws1    wd1          rs0    rs1    re    rsl    fl    e_rd0         e_rd1         rb0   rb1   ok    e_busy
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       5'd5,  5'd5,  1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd0,  5'd5,  1'b0, 5'd0,  1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,       5'd0,  5'd5,  1'b1, 5'd0,  1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'hAAAA,     1'b1, 5'd7,  32'h5555,    5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'h5555,     32'h5555,     1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd7,  5'd5,  1'b1, 5'd3,  1'b0, 32'h5555,     32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h8};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd3,  5'd5,  1'b1, 5'd3,  1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h8};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,      5'd3,  5'd5,  1'b0, 5'd0,  1'b0, 32'h33,       32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  32'h0,       5'd3,  5'd9,  1'b1, 5'd9,  1'b0, 32'h33,       32'h99,       1'b0, 1'b0, 1'b1, 32'h200};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd3,  5'd9,  1'b1, 5'd4,  1'b0, 32'h33,       32'h99,       1'b0, 1'b1, 1'b1, 32'h210};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd4,  5'd9,  1'b1, 5'd12, 1'b1, 32'h0,        32'h99,       1'b1, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd4,  5'd9,  1'b0, 5'd0,  1'b0, 32'h0,        32'h99,       1'b0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 5'd10, 32'hA0A0,     1'b0, 5'd0,  32'h0,       5'd10, 5'd9,  1'b0, 5'd0,  1'b1, 32'hA0A0,     32'h99,       1'b0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd10, 5'd7,  1'b1, 5'd10, 1'b0, 32'hA0A0,     32'h5555,     1'b0, 1'b0, 1'b1, 32'h400};
        vecs[14] = '{1'b1, 5'd10, 32'h1,        1'b1, 5'd2,  32'h2,       5'd10, 5'd2,  1'b0, 5'd0,  1'b0, 32'h1,        32'h2,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd10, 5'd2,  1'b0, 5'd0,  1'b0, 32'h1,        32'h2,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd10, 5'd2,  1'b1, 5'd6,  1'b0, 32'h1,        32'h2,        1'b0, 1'b0, 1'b1, 32'h40};

        // Idle inputs on both instances, reset asserted
        nRST = 1'b0;
        bus_a.wen = '0; bus_a.wsel = '0; bus_a.wdat = '0; bus_a.rsel = '0;
        bus_a.rsv_en = 1'b0; bus_a.rsv_sel = '0; bus_a.flush = 1'b0;
        bus_b.wen = '0; bus_b.wsel = '0; bus_b.wdat = '0; bus_b.rsel = '0;
        bus_b.rsv_en = 1'b0; bus_b.rsv_sel = '0; bus_b.flush = 1'b0;
        for (int r = 0; r < 16; r++) regs_m[r] = '0;
        busy_m = '0;

        repeat (2) @(posedge CLK);
        #1;
        bus_a.rsv_en = 1'b1; bus_a.rsv_sel = 5'd3;
        #1;
        chk("reset busy_a",  bus_a.busy,   32'h0);
        chk("reset busy_b",  bus_b.busy,   16'h0);
        chk("reset rdat_a",  bus_a.rdat,   64'h0);
        chk("reset rsv_ok",  bus_a.rsv_ok, 1'b0);
        chk("reset rbusy_b", bus_b.rbusy,  4'h0);
        bus_a.rsv_en = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // Directed vector table on the default configuration
        for (int k = 0; k < NVEC; k++) begin
            @(negedge CLK);
            bus_a.wen     = {vecs[k].w1, vecs[k].w0};
            bus_a.wsel[0] = vecs[k].ws0; bus_a.wdat[0] = vecs[k].wd0;
            bus_a.wsel[1] = vecs[k].ws1; bus_a.wdat[1] = vecs[k].wd1;
            bus_a.rsel[0] = vecs[k].rs0; bus_a.rsel[1] = vecs[k].rs1;
            bus_a.rsv_en  = vecs[k].re;  bus_a.rsv_sel = vecs[k].rsl;
            bus_a.flush   = vecs[k].fl;
            #1;
            chk($sformatf("v%0d rdat0", k),  bus_a.rdat[0],  vecs[k].e_rd0);
            chk($sformatf("v%0d rdat1", k),  bus_a.rdat[1],  vecs[k].e_rd1);
            chk($sformatf("v%0d rbusy0", k), bus_a.rbusy[0], vecs[k].e_rb0);
            chk($sformatf("v%0d rbusy1", k), bus_a.rbusy[1], vecs[k].e_rb1);
            chk($sformatf("v%0d rsv_ok", k), bus_a.rsv_ok,   vecs[k].e_ok);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d busy", k),   bus_a.busy,     vecs[k].e_busy);
        end

        // Reset between clock edges with live state; pending reserve and write lost
        @(negedge CLK);
        bus_a.wen = '0; bus_a.flush = 1'b0;
        bus_a.rsel[0] = 5'd10; bus_a.rsel[1] = 5'd6;
        bus_a.rsv_en = 1'b1; bus_a.rsv_sel = 5'd11;
        #1;
        chk("pre-rst rdat0",  bus_a.rdat[0],  32'h1);
        chk("pre-rst rbusy1", bus_a.rbusy[1], 1'b1);
        chk("pre-rst rsv_ok", bus_a.rsv_ok,   1'b1);
        #1;
        nRST = 1'b0;
        #1;
        chk("rst rdat0",  bus_a.rdat[0],  32'h0);
        chk("rst rbusy1", bus_a.rbusy[1], 1'b0);
        chk("rst busy",   bus_a.busy,     32'h0);
        chk("rst rsv_ok", bus_a.rsv_ok,   1'b0);
        bus_a.rsv_en = 1'b0;
        bus_a.wen = 2'b01; bus_a.wsel[0] = 5'd6; bus_a.wdat[0] = 32'h66;
        @(negedge CLK);
        bus_a.wen = '0;
        nRST = 1'b1;
        #1;
        chk("post-rst rdat1", bus_a.rdat[1], 32'h0);
        @(posedge CLK);
        #1;
        chk("post-rst busy", bus_a.busy, 32'h0);

        // Random sweep of the 16-entry, 4R/1W, no-bypass instance
        for (int c = 0; c < 400; c++) begin
            logic [3:0]  rs[4];
            logic        we, re, fl, ok;
            logic [3:0]  ws, rsl;
            logic [31:0] wd;
            exp_t        e, got;
            @(negedge CLK);
            we  = ($urandom_range(0, 2) != 0);
            ws  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            re  = ($urandom_range(0, 1) != 0);
            rsl = 4'($urandom_range(0, 15));
            fl  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 4; i++) begin
                rs[i] = 4'($urandom_range(0, 15));
                bus_b.rsel[i] = rs[i];
            end
            bus_b.wen[0] = we; bus_b.wsel[0] = ws; bus_b.wdat[0] = wd;
            bus_b.rsv_en = re; bus_b.rsv_sel = rsl; bus_b.flush = fl;

            ok = re && !fl && ((rsl == 4'd0) || !busy_m[rsl]);
            for (int i = 0; i < 4; i++) begin
                e.rd[i] = regs_m[rs[i]];
                e.rb[i] = busy_m[rs[i]];
            end
            e.ok = ok;
            e.bz = busy_m;
            sb.push_back(e);

            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sweep scoreboard empty at cycle %0d", c);
            end else begin
                got = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("sw%0d rdat%0d", c, i), bus_b.rdat[i], got.rd[i]);
                end
                chk($sformatf("sw%0d rbusy", c),  bus_b.rbusy,  got.rb);
                chk($sformatf("sw%0d rsv_ok", c), bus_b.rsv_ok, got.ok);
                chk($sformatf("sw%0d busy", c),   bus_b.busy,   got.bz);
            end

            if (we && ws != 4'd0) regs_m[ws] = wd;
            if (fl) begin
                busy_m = '0;
            end else begin
                if (we) busy_m[ws] = 1'b0;
                if (ok && rsl != 4'd0) busy_m[rsl] = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
